// File: rtl/program_loader.sv
// Serial program loader for the paper processor: shifts in a program,
// then gates the core clock-enable until the decoder halts.
module program_loader #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              halt_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              run_en,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count
);

  localparam int PH_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WIDTH-2:0]  sh_q, sh_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic accept;
  logic last_bit;

  assign accept   = bit_valid && bit_ready;
  assign last_bit = (phase_q == PH_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      phase_q  <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      phase_q  <= phase_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    phase_d  = phase_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    bit_ready = 1'b0;
    run_en    = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          phase_d  = '0;
          cnt_d    = '0;
        end
      end
      S_LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        // Abort wins over a bit presented in the same cycle.
        if (load_abort) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else if (accept) begin
          if (!last_bit) begin
            sh_d    = (sh_q << 1) | (WIDTH-1)'(bit_in);
            phase_d = phase_q + 1'b1;
          end else begin
            mem_d[wr_ptr_q] = {sh_q, bit_in};
            phase_d  = '0;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (cnt_q != (ADDR_W+1)'(DEPTH)) cnt_d = cnt_q + 1'b1;
            if (wr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        run_en = 1'b1;
        if (halt_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_data    = mem_q[rd_addr];
  assign word_count = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader against a word-level
// model of the program memory and load counter.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, load_abort, bit_in, bit_valid, halt_in;
  logic       bit_ready, run_en, busy, load_done;
  logic [1:0] rd_addr, rd_data;
  logic [2:0] word_count;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_mem [4];
  int         m_cnt;
  logic [1:0] prog [4];

  always #5 clk = ~clk;

  program_loader #(.DEPTH(4), .WIDTH(2), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_abort(load_abort),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .halt_in(halt_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .run_en(run_en), .busy(busy), .load_done(load_done),
    .word_count(word_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk($sformatf("%s mem[%0d]", tag, a), int'(rd_data), int'(m_mem[a]));
    end
  endtask

  task automatic chk_ctl(input string tag, input int rdy, input int run,
                         input int bsy, input int dn);
    chk({tag, " bit_ready"}, int'(bit_ready), rdy);
    chk({tag, " run_en"}, int'(run_en), run);
    chk({tag, " busy"}, int'(busy), bsy);
    chk({tag, " load_done"}, int'(load_done), dn);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    for (int a = 0; a < 4; a++) m_mem[a] = 2'b00;
    m_cnt = 0;
    chk_ctl("reset", 0, 0, 0, 0);
    chk("reset word_count", int'(word_count), 0);
    chk_mem("reset");
    rst_n = 1'b1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    m_cnt = 0;
    chk_ctl("start", 1, 0, 1, 0);
    chk("start word_count", int'(word_count), 0);
  endtask

  // Streams bit k (0-based, MSB of each word first) of prog[] to the DUT.
  task automatic send_bit(input int k, input int gap, input bit noise);
    for (int g = 0; g < gap; g++) begin
      bit_valid  = 1'b0;
      load_start = noise;
      halt_in    = noise;
      step();
    end
    load_start = 1'b0;
    halt_in    = 1'b0;
    bit_valid  = 1'b1;
    bit_in     = prog[k/2][1 - (k % 2)];
    step();
    bit_valid  = 1'b0;
    if (k % 2 == 1) begin
      m_mem[k/2] = prog[k/2];
      m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    end
  endtask

  task automatic full_load(input string tag, input int maxgap, input bit noise);
    start_load();
    for (int k = 0; k < 8; k++) begin
      send_bit(k, (maxgap < 0) ? -maxgap : int'($urandom_range(0, maxgap)),
               noise);
      if (k < 7) begin
        chk({tag, " load_done early"}, int'(load_done), 0);
        chk({tag, " word_count"}, int'(word_count), m_cnt);
      end
    end
    chk_ctl({tag, " done"}, 0, 0, 1, 1);
    chk({tag, " word_count"}, int'(word_count), 4);
    step();
    chk_ctl({tag, " run"}, 0, 1, 0, 0);
    chk_mem(tag);
  endtask

  task automatic halt();
    halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    chk_ctl("halt", 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_abort = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; halt_in = 1'b0; rd_addr = 2'd0;
    step();
    do_reset();

    // Directed program 01,10,11,00 back-to-back.
    prog[0] = 2'b01; prog[1] = 2'b10; prog[2] = 2'b11; prog[3] = 2'b00;
    full_load("b2b", 0, 1'b0);
    // bit_valid in RUN must be ignored.
    bit_valid = 1'b1; bit_in = 1'b1;
    step(); step();
    bit_valid = 1'b0;
    chk_ctl("run ignore", 0, 1, 0, 0);
    chk_mem("run ignore");
    halt();

    // Same program with 3 idle cycles between bits.
    for (int a = 0; a < 4; a++) m_mem[a] = 2'b00;
    full_load("gap3", -3, 1'b0);
    halt();

    // IDLE ignores halt_in and bit_valid.
    halt_in = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step(); step(); step();
    halt_in = 1'b0; bit_valid = 1'b0;
    chk_ctl("idle ignore", 0, 0, 0, 0);
    chk("idle word_count", int'(word_count), 4);
    chk_mem("idle ignore");

    // Abort after bits 1,0,1: only word 0 survives.
    do_reset();
    prog[0] = 2'b10; prog[1] = 2'b11;
    start_load();
    for (int k = 0; k < 3; k++) send_bit(k, 0, 1'b0);
    load_abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    load_abort = 1'b0; bit_valid = 1'b0;
    chk_ctl("abort", 0, 0, 0, 0);
    chk("abort word_count", int'(word_count), 1);
    chk_mem("abort");

    // Random program with load_start/halt_in noise during LOAD.
    for (int a = 0; a < 4; a++) prog[a] = 2'($urandom_range(0, 3));
    full_load("rnd1", 2, 1'b1);

    // halt_in together with load_start: halt only.
    halt_in = 1'b1; load_start = 1'b1;
    step();
    halt_in = 1'b0; load_start = 1'b0;
    chk_ctl("halt+start", 0, 0, 0, 0);
    step();
    chk_ctl("no load", 0, 0, 0, 0);
    chk_mem("no load");

    for (int a = 0; a < 4; a++) prog[a] = 2'($urandom_range(0, 3));
    full_load("reload", 2, 1'b0);
    halt();

    // Reset after 5 bits of a load.
    for (int a = 0; a < 4; a++) prog[a] = 2'($urandom_range(0, 3));
    start_load();
    for (int k = 0; k < 5; k++) send_bit(k, int'($urandom_range(0, 1)), 1'b0);
    do_reset();
    for (int a = 0; a < 4; a++) prog[a] = 2'($urandom_range(0, 3));
    full_load("post-rst", 1, 1'b0);

    // Randomized loads with abort/halt cycles mixed in.
    for (int it = 0; it < 6; it++) begin
      halt();
      for (int a = 0; a < 4; a++) prog[a] = 2'($urandom_range(0, 3));
      if (it % 2 == 1) begin
        int n = int'($urandom_range(1, 7));
        start_load();
        for (int k = 0; k < n; k++) send_bit(k, int'($urandom_range(0, 2)), 1'b1);
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        chk_ctl("rnd abort", 0, 0, 0, 0);
        chk("rnd abort word_count", int'(word_count), n / 2);
        chk_mem("rnd abort");
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        full_load("rnd after abort", 2, 1'b1);
      end else begin
        full_load("rnd", 3, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the paper processor: loads the 4-word x 2-bit program memory from a serial bit stream, then enables the core.
- Serves the core's program-counter read port combinationally.
- Drives the core's clock-enable (run_en) only after a complete program is loaded.
- Returns to idle on the decoder's halt so a new program can be loaded.

Parameters:
- DEPTH, 4, number of program words (power of two).
- WIDTH, 2, instruction width in bits.
- ADDR_W, 2, address width = log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- load_start  input  1  pulse; begins a load from IDLE.
- load_abort  input  1  abandons a load in progress.
- bit_in  input  1  serial program bit, MSB of each word first.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader accepts a bit this cycle.
- halt_in  input  1  halt strobe from the instruction decoder.
- rd_addr  input  ADDR_W  program-counter address from the core.
- rd_data  output  WIDTH  instruction at rd_addr.
- run_en  output  1  clock-enable to the processor core.
- busy  output  1  high in LOAD and DONE.
- load_done  output  1  one-cycle pulse when the last word is written.
- word_count  output  ADDR_W+1  words written in the current or last load (0..DEPTH).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - All memory words = 0.
  - wr_ptr=0, bit phase=0, word_count=0.
  - bit_ready=0, run_en=0, busy=0, load_done=0.
  - Reset overrides every other input in the same cycle, including mid-LOAD and RUN.
- States: IDLE, LOAD, DONE, RUN.
- IDLE:
  - Outputs: bit_ready=0, run_en=0.
  - load_start=1 -> LOAD on the next cycle; clear wr_ptr, bit phase and word_count.
  - halt_in ignored.
- LOAD:
  - Outputs: bit_ready=1, busy=1.
  - A bit is accepted when bit_valid && bit_ready.
  - Phase 0: capture bit as the word MSB.
  - Phase 1: write mem[wr_ptr] = {captured MSB, bit_in} in the same cycle, then wr_ptr+1 and word_count+1.
  - Cycles with bit_valid=0 stall with no state change; gaps between bits are unlimited.
  - Writing word DEPTH-1 -> DONE next cycle. wr_ptr wraps to 0 and word_count=DEPTH.
  - load_abort=1 -> IDLE next cycle; the bit on that cycle is not accepted.
    - Words already written remain in memory.
    - A half-captured word is discarded.
    - word_count holds the number of words completed.
  - load_start and halt_in ignored.
- DONE:
  - Lasts exactly one cycle; load_done=1, busy=1, bit_ready=0.
  - Then -> RUN.
- RUN:
  - run_en=1 from the first RUN cycle, i.e. 2 cycles after the final bit is accepted.
  - halt_in=1 -> IDLE next cycle; run_en=0 from that cycle.
  - load_start ignored; bit_valid ignored (bit_ready=0).
- Simultaneous inputs:
  - load_abort has priority over bit acceptance in LOAD.
  - halt_in has priority in RUN; load_start is ignored in RUN even when it coincides with halt_in.
- Read port:
  - rd_data = mem[rd_addr], combinational and valid in every state.
  - A same-cycle write to that address shows the old value until the next edge.
- Memory writes occur only in LOAD.
- word_count saturates at DEPTH and is never exceeded.

Test Plan:
- Reset, then full load of words 2'b01,2'b10,2'b11,2'b00: assert load_start for 1 cycle, then stream bits 0,1,1,0,1,1,0,0 back-to-back.
  - Expect load_done for exactly 1 cycle, 1 cycle after the 8th bit.
  - Expect run_en=1 on the next cycle.
  - Expect rd_data for addr 0..3 = 01,10,11,00; word_count=4.
- Same stream with bit_valid low for 3 cycles between every bit -> identical memory contents; load_done 1 cycle after the last bit.
- Abort after 3 bits (1,0,1) -> IDLE.
  - Expect mem[0]=10, mem[1] unchanged (00 after reset), word_count=1, run_en=0.
- In RUN, assert halt_in together with load_start -> run_en=0 next cycle, state IDLE, no load started.
  - A later load_start then reloads all 4 words.
- Assert rst_n=0 after 5 bits of a load -> next cycle all words 0, word_count=0, bit_ready=0, run_en=0.
  - A fresh 8-bit load then completes normally.
- Pulse halt_in and drive bit_valid in IDLE, and assert load_start in LOAD -> no state, memory or word_count change.
